snake_game_ctrl: RTL and testbench

//  Game sequencer for the VGA snake game. Owns the RUN/OVER/WIN state machine,
//  the movement tick, the per-step direction commit, size/score bookkeeping and
//  the apple-respawn request. Consumes collision flags from the pixel datapath
//  and drives the body shift register and the apple placer.

---
 rtl/snake_game_ctrl.sv | 166 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the VGA snake: RUN/OVER/WIN FSM, step tick, turn commit, size and apple respawn.
// Define SPEEDUP_EN to shorten the step period by TICK_DEC per apple eaten, floored at TICK_MIN.
module snake_game_ctrl #(
    parameter int TICK_INIT = 1777777,
    parameter int TICK_MIN  = 400000,
    parameter int TICK_DEC  = 100000,
    parameter int MAX_SIZE  = 16
) (
    input  logic       master_clk,
    input  logic       B_reset,
    input  logic       start,
    input  logic       dir_btn,
    input  logic       eat,
    input  logic       hit,
    output logic       step,
    output logic [4:0] direction,
    output logic [6:0] size,
    output logic       respawn,
    output logic       game_over,
    output logic       win,
    output logic [1:0] state_dbg
);

    localparam int TICK_TOP = (TICK_MIN + TICK_DEC > TICK_INIT) ? (TICK_MIN + TICK_DEC) : TICK_INIT;
    localparam int CW = $clog2(TICK_TOP + 1);
    localparam logic [CW-1:0] PERIOD_INIT = CW'(TICK_INIT);
    localparam logic [6:0] SIZE_MAX = 7'(MAX_SIZE);

    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] period;
    logic [CW-1:0] period_dec;
    logic          pend_turn;
    logic          eat_q;
    logic          tick_due;
    logic          eat_edge;
    logic          eat_evt;
    logic          turn_req;
    logic          at_win;
    logic [4:0]    dir_cw;

    // >= rather than == so a period shortened below the running count wraps at once
    assign tick_due = (cnt >= period - CW'(1));
    assign eat_edge = eat & ~eat_q;
    assign at_win   = (size >= SIZE_MAX - 7'd1);

`ifdef SPEEDUP_EN
    localparam logic [CW-1:0] P_MIN = CW'(TICK_MIN);
    localparam logic [CW-1:0] P_DEC = CW'(TICK_DEC);

    always_comb begin
        period_dec = P_MIN;
        if (period > P_MIN + P_DEC) begin
            period_dec = period - P_DEC;
        end
    end
`else
    assign period_dec = PERIOD_INIT;
`endif

    always_comb begin
        dir_cw = DIR_UP;
        case (direction)
            DIR_UP:    dir_cw = DIR_RIGHT;
            DIR_RIGHT: dir_cw = DIR_DOWN;
            DIR_DOWN:  dir_cw = DIR_LEFT;
            DIR_LEFT:  dir_cw = DIR_UP;
            default:   dir_cw = DIR_UP;
        endcase
    end

    always_ff @(posedge master_clk) begin
        if (B_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        eat_evt   = 1'b0;
        turn_req  = 1'b0;
        if (B_reset || !start) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_RUN;
                S_RUN: begin
                    // hit wins over everything else in the cycle: no step, eat dropped
                    if (hit) begin
                        state_nxt = S_OVER;
                    end else begin
                        step     = tick_due;
                        eat_evt  = eat_edge;
                        turn_req = dir_btn;
                        if (eat_edge && at_win) begin
                            state_nxt = S_WIN;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
        game_over = (state == S_OVER);
        win       = (state == S_WIN);
        state_dbg = state;
    end

    always_ff @(posedge master_clk) begin
        if (B_reset) begin
            eat_q <= 1'b0;
        end else begin
            eat_q <= eat;
        end
    end

    always_ff @(posedge master_clk) begin
        if (B_reset || !start) begin
            cnt       <= '0;
            period    <= PERIOD_INIT;
            pend_turn <= 1'b0;
            direction <= DIR_UP;
            size      <= 7'd1;
            respawn   <= 1'b0;
        end else begin
            respawn <= 1'b0;
            if (state == S_RUN) begin
                cnt <= tick_due ? '0 : cnt + CW'(1);
            end
            // one turn per step: later presses are dropped while a turn is pending
            if (step) begin
                if (pend_turn) begin
                    direction <= dir_cw;
                    pend_turn <= 1'b0;
                end
            end else if (turn_req) begin
                pend_turn <= 1'b1;
            end
            if (eat_evt) begin
                period <= period_dec;
                if (at_win) begin
                    size <= SIZE_MAX;
                end else begin
                    size    <= size + 7'd1;
                    respawn <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small tick values (10/4/3, MAX_SIZE 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_snake_game_ctrl;

    localparam int TICK_INIT = 10;
    localparam int TICK_MIN  = 4;
    localparam int TICK_DEC  = 3;
    localparam int MAX_SIZE  = 4;

    localparam logic [4:0] D_UP    = 5'b00010;
    localparam logic [4:0] D_RIGHT = 5'b10000;
    localparam logic [4:0] D_DOWN  = 5'b01000;

    logic       master_clk = 1'b0;
    logic       B_reset;
    logic       start;
    logic       dir_btn;
    logic       eat;
    logic       hit;
    logic       step;
    logic [4:0] direction;
    logic [6:0] size;
    logic       respawn;
    logic       game_over;
    logic       win;
    logic [1:0] state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       rst;
        logic       s;
        logic       d;
        logic       e;
        logic       h;
        logic       x_step;
        logic       x_resp;
        logic [4:0] x_dir;
        logic [6:0] x_size;
        logic       x_over;
        logic       x_win;
    } vec_t;

    vec_t tbl[27];
    int   steps[6];

    always #5 master_clk = ~master_clk;

    snake_game_ctrl #(
        .TICK_INIT(TICK_INIT),
        .TICK_MIN (TICK_MIN),
        .TICK_DEC (TICK_DEC),
        .MAX_SIZE (MAX_SIZE)
    ) dut (
        .master_clk(master_clk),
        .B_reset   (B_reset),
        .start     (start),
        .dir_btn   (dir_btn),
        .eat       (eat),
        .hit       (hit),
        .step      (step),
        .direction (direction),
        .size      (size),
        .respawn   (respawn),
        .game_over (game_over),
        .win       (win),
        .state_dbg (state_dbg)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic e,
                                input logic h, input logic xs, input logic xr,
                                input logic [4:0] xd, input logic [6:0] xz,
                                input logic xo, input logic xw);
        vec_t v;
        v.rst = r; v.s = s; v.d = d; v.e = e; v.h = h;
        v.x_step = xs; v.x_resp = xr; v.x_dir = xd; v.x_size = xz;
        v.x_over = xo; v.x_win = xw;
        return v;
    endfunction

    task automatic check(input string nm, input int c, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0d: got %0h, expected %0h", nm, c, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic x_step,
                             input logic x_resp, input logic [4:0] x_dir,
                             input logic [6:0] x_size, input logic x_over, input logic x_win);
        check({tag, ".step"}, c, step, x_step);
        check({tag, ".respawn"}, c, respawn, x_resp);
        check({tag, ".direction"}, c, direction, x_dir);
        check({tag, ".size"}, c, size, x_size);
        check({tag, ".game_over"}, c, game_over, x_over);
        check({tag, ".win"}, c, win, x_win);
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic e,
                         input logic h);
        @(posedge master_clk);
        #1;
        B_reset = r;
        start   = s;
        dir_btn = d;
        eat     = e;
        hit     = h;
        @(negedge master_clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        B_reset = 1'b1;
        start   = 1'b0;
        dir_btn = 1'b0;
        eat     = 1'b0;
        hit     = 1'b0;

        // eat/win, eat+hit, OVER/WIN input masking and mid-game reset, one row per cycle
        tbl[0]  = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0,  0, 1, D_UP, 7'd2, 0, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd2, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0,  0, 1, D_UP, 7'd3, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd3, 0, 0);
        tbl[6]  = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd4, 0, 1);
        tbl[7]  = mk(0, 1, 1, 0, 0,  0, 0, D_UP, 7'd4, 0, 1);
        tbl[8]  = mk(0, 1, 0, 1, 1,  0, 0, D_UP, 7'd4, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, D_UP, 7'd4, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[12] = mk(0, 1, 0, 1, 1,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[13] = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd1, 1, 0);
        tbl[14] = mk(0, 1, 1, 0, 0,  0, 0, D_UP, 7'd1, 1, 0);
        tbl[15] = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd1, 1, 0);
        tbl[16] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, D_UP, 7'd1, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[20] = mk(0, 1, 1, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[21] = mk(0, 1, 0, 1, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[22] = mk(1, 1, 0, 0, 0,  0, 1, D_UP, 7'd2, 0, 0);
        tbl[23] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[24] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[25] = mk(1, 1, 0, 1, 0,  0, 0, D_UP, 7'd1, 0, 0);
        tbl[26] = mk(0, 1, 0, 0, 0,  0, 0, D_UP, 7'd1, 0, 0);

`ifdef SPEEDUP_EN
        steps = '{10, 17, 21, 25, 29, 33};
`else
        steps = '{10, 20, 30, 40, 50, 60};
`endif

        // reset values while B_reset is held
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("reset", 0, 1'b0, 1'b0, D_UP, 7'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // step timing, one-turn-per-step, held eat, eat+hit on a step cycle, OVER masking
        for (int c = 0; c <= 72; c++) begin
            logic       d, e, h, x_step;
            logic [4:0] x_dir;
            d = (c == 12) || (c == 14) || (c == 16) || (c == 23) || (c == 62);
            e = (c >= 33 && c <= 52) || (c == 60) || (c == 63);
            h = (c == 60);
            drive(1'b0, 1'b1, d, e, h);
            x_step = (c > 0) && (c < 60) && (c % 10 == 0);
            x_dir  = (c <= 20) ? D_UP : ((c <= 30) ? D_RIGHT : D_DOWN);
            check_all("run", c, x_step, (c == 34), x_dir,
                      (c >= 34) ? 7'd2 : 7'd1, (c >= 61), 1'b0);
        end

        do_reset();
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst, tbl[i].s, tbl[i].d, tbl[i].e, tbl[i].h);
            check_all("tbl", i, tbl[i].x_step, tbl[i].x_resp, tbl[i].x_dir,
                      tbl[i].x_size, tbl[i].x_over, tbl[i].x_win);
        end

        // step period after eats, then B_reset on a due step and the restart timing
        do_reset();
        for (int c = 0; c <= steps[5] + 12; c++) begin
            logic       r, e, x_step, x_resp;
            logic [6:0] x_size;
            r = (c == steps[5]);
            e = (c == steps[0]) || (c == steps[1]);
            drive(r, 1'b1, 1'b0, e, 1'b0);
            x_step = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (c == steps[k]) x_step = 1'b1;
            end
            if (c == steps[5] + 11) x_step = 1'b1;
            x_resp = (c == steps[0] + 1) || (c == steps[1] + 1);
            if (c > steps[5]) x_size = 7'd1;
            else if (c > steps[1]) x_size = 7'd3;
            else if (c > steps[0]) x_size = 7'd2;
            else x_size = 7'd1;
            check_all("speed", c, x_step, x_resp, D_UP, x_size, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
